i2c_target_regs: RTL and testbench

I2C target (responder) that exposes a 16 x 8-bit register file to an external I2C controller and to the SoC over the iomem-style valid/ready bus. It is the far end of the I2C controller in the hard-IP wrapper: a board-level companion device or a loopback target on the same pins. It is instantiated beside the other iomem peripherals. It decodes one iomem address window; address decode is done by the top level.

---
 rtl/i2c_target_regs_if.sv | 28 ++
 rtl/i2c_target_regs.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regs_if.sv
// Local register bus: valid/ready request with write strobe and 32-bit data.
// master = SoC side driving requests; slave = register block answering them.
interface i2c_target_regs_if;
  logic        reg_valid;
  logic        reg_ready;
  logic [3:0]  reg_wstrb;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_valid,
    output reg_wstrb,
    output reg_addr,
    output reg_wdata,
    input  reg_ready,
    input  reg_rdata
  );

  modport slave (
    input  reg_valid,
    input  reg_wstrb,
    input  reg_addr,
    input  reg_wdata,
    output reg_ready,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing 16x8 registers to an I2C controller and a local bus.
// Ports: clk, resetn (sync, low), scl_i/sda_i pads, sda_oe, bus, wr_evt, busy.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR = 7'h42
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  i2c_target_regs_if.slave      bus,
  output logic                  wr_evt,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
  } state_t;

  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_dly_q, sda_dly_q;
  logic        scl_s, sda_s;
  logic        rise, fall, start, stop;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        evt_q, evt_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic [7:0]  byte_in;
  logic        unused_ok;

  assign unused_ok = ^{bus.reg_wstrb[3:1], bus.reg_wdata[31:8]};

  // Synchronizers idle high so reset release does not fake an edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
    end
  end

  assign scl_s   = scl_sync_q[1];
  assign sda_s   = sda_sync_q[1];
  assign rise    = scl_s & ~scl_dly_q;
  assign fall    = ~scl_s & scl_dly_q;
  assign start   = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop    = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign byte_in = {sh_q[6:0], sda_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    evt_d   = 1'b0;
    rdy_d   = 1'b0;
    rdata_d = rdata_q;
    regs_d  = regs_q;

    if (bus.reg_valid && !rdy_q) begin
      rdy_d   = 1'b1;
      rdata_d = {24'h0, regs_q[bus.reg_addr]};
      if (bus.reg_wstrb[0])
        regs_d[bus.reg_addr] = bus.reg_wdata[7:0];
    end

    // I2C side is evaluated after the local write so it wins a collision.
    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (rise && cnt_q != 4'd8) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (sh_q[7:1] == I2C_ADDR) begin
              state_d = ADDR_ACK;
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = sh_q[0];
            end else begin
              state_d = WAIT;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            if (rw_q) begin
              state_d = RDATA;
              sh_d    = regs_q[ptr_q];
              oe_d    = ~regs_q[ptr_q][7];
            end else begin
              state_d = PTR;
              oe_d    = 1'b0;
            end
          end
        end
        PTR: begin
          if (rise && cnt_q != 4'd8) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7)
              ptr_d = byte_in[3:0];
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = PTR_ACK;
            oe_d    = 1'b1;
          end
        end
        WDATA: begin
          if (rise && cnt_q != 4'd8) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              regs_d[ptr_q] = byte_in;
              evt_d         = 1'b1;
              ptr_d         = ptr_q + 4'd1;
            end
          end else if (fall && cnt_q == 4'd8) begin
            cnt_d   = '0;
            state_d = WDATA_ACK;
            oe_d    = 1'b1;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (fall) begin
            state_d = WDATA;
            oe_d    = 1'b0;
          end
        end
        RDATA: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = '0;
              state_d = RDATA_ACK;
              oe_d    = 1'b0;
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
              oe_d = ~sh_q[6];
            end
          end
        end
        RDATA_ACK: begin
          // cnt_q==1 marks an ACK seen on the 9th rise.
          if (rise) begin
            if (sda_s) begin
              state_d = WAIT;
            end else begin
              ptr_d = ptr_q + 4'd1;
              cnt_d = 4'd1;
            end
          end else if (fall && cnt_q == 4'd1) begin
            state_d = RDATA;
            cnt_d   = '0;
            sh_d    = regs_q[ptr_q];
            oe_d    = ~regs_q[ptr_q][7];
          end
        end
        IDLE, WAIT: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      regs_q  <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      regs_q  <= regs_d;
    end
  end

  assign sda_oe        = oe_q;
  assign wr_evt        = evt_q;
  assign busy          = busy_q;
  assign bus.reg_ready = rdy_q;
  assign bus.reg_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller plus local bus,
// compared against a plain array/pointer model of the register file.
module tb_i2c_target_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic scl_drv, sda_drv;
  logic sda_oe, wr_evt, busy;
  logic sda_line;

  assign sda_line = sda_drv & ~sda_oe;

  i2c_target_regs_if bus ();

  i2c_target_regs #(.I2C_ADDR(7'h42)) dut (
    .clk    (clk),
    .resetn (resetn),
    .scl_i  (scl_drv),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .bus    (bus),
    .wr_evt (wr_evt),
    .busy   (busy)
  );

  int checks = 0;
  int failures = 0;
  int evt_cnt = 0;
  int oe_cnt = 0;

  logic [7:0] mregs [16];
  logic [3:0] mptr;
  logic [7:0] wbuf [8];

  always @(posedge clk) begin
    if (wr_evt) evt_cnt <= evt_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic local_acc(input logic [3:0] a, input logic we,
                           input logic [7:0] wd, input string tag);
    logic [31:0] r;
    r = $urandom;
    bus.reg_valid = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wstrb = we ? 4'h1 : 4'h0;
    bus.reg_wdata = {r[31:8], wd};
    clks(1);
    check("loc_ready", 32'(bus.reg_ready), 32'd1);
    check(tag, bus.reg_rdata, {24'h0, mregs[a]});
    bus.reg_valid = 1'b0;
    if (we) mregs[a] = wd;
    clks(1);
    check("loc_ready_drop", 32'(bus.reg_ready), 32'd0);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; clks(4);
    scl_drv = 1'b1; clks(8);
    sda_drv = 1'b0; clks(8);
    scl_drv = 1'b0; clks(4);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; clks(4);
    scl_drv = 1'b1; clks(8);
    sda_drv = 1'b1; clks(8);
  endtask

  // Optional local write landing on the same clk as the I2C data write.
  task automatic send_byte(input logic [7:0] b, input logic cl_en,
                           input logic [3:0] cl_a, input logic [7:0] cl_d,
                           output logic ack);
    for (int i = 7; i >= 0; i--) begin
      clks(4); sda_drv = b[i];
      clks(4); scl_drv = 1'b1;
      if (i == 0 && cl_en) begin
        clks(2);
        bus.reg_valid = 1'b1;
        bus.reg_addr  = cl_a;
        bus.reg_wstrb = 4'h1;
        bus.reg_wdata = {24'h0, cl_d};
        clks(1);
        check("coll_ready", 32'(bus.reg_ready), 32'd1);
        check("coll_rdata", bus.reg_rdata, {24'h0, mregs[cl_a]});
        bus.reg_valid = 1'b0;
        mregs[cl_a] = cl_d;
        clks(5);
      end else begin
        clks(8);
      end
      scl_drv = 1'b0;
    end
    clks(4); sda_drv = 1'b1;
    clks(4); scl_drv = 1'b1;
    clks(4); ack = ~sda_line;
    clks(4); scl_drv = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    clks(8); scl_drv = 1'b1;
    clks(4); b = sda_line;
    clks(4); scl_drv = 1'b0;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic bt;
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      read_bit(bt);
      b[i] = bt;
    end
    clks(4); sda_drv = nack;
    clks(4); scl_drv = 1'b1;
    clks(8); scl_drv = 1'b0;
    clks(4); sda_drv = 1'b1;
  endtask

  task automatic set_ptr(input logic [3:0] p);
    logic a;
    logic [3:0] hi;
    hi = 4'($urandom_range(0, 15));
    i2c_start();
    send_byte(8'h84, 1'b0, 4'h0, 8'h0, a);
    check("addr_w_ack", 32'(a), 32'd1);
    check("busy_on", 32'(busy), 32'd1);
    send_byte({hi, p}, 1'b0, 4'h0, 8'h0, a);
    check("ptr_ack", 32'(a), 32'd1);
    mptr = p;
  endtask

  task automatic i2c_wr(input logic [3:0] p, input int n,
                        input logic cl_en, input logic [3:0] cl_a,
                        input logic [7:0] cl_d);
    logic a;
    int e0;
    e0 = evt_cnt;
    set_ptr(p);
    for (int k = 0; k < n; k++) begin
      send_byte(wbuf[k], cl_en && k == 0, cl_a, cl_d, a);
      check("data_ack", 32'(a), 32'd1);
      mregs[mptr] = wbuf[k];
      mptr = mptr + 4'd1;
    end
    i2c_stop();
    check("wr_evt_count", 32'(evt_cnt - e0), 32'(n));
    check("busy_off", 32'(busy), 32'd0);
  endtask

  task automatic i2c_rd(input logic [3:0] p, input int n);
    logic a;
    logic [7:0] b;
    set_ptr(p);
    i2c_start();
    send_byte(8'h85, 1'b0, 4'h0, 8'h0, a);
    check("addr_r_ack", 32'(a), 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, b);
      check("rd_data", 32'(b), 32'(mregs[mptr]));
      if (k != n - 1) mptr = mptr + 4'd1;
    end
    check("rd_release", 32'(sda_oe), 32'd0);
    i2c_stop();
    check("busy_off_rd", 32'(busy), 32'd0);
  endtask

  initial begin
    logic a;
    logic b;
    int o0;
    int n;
    logic [3:0] p;

    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'h0;
    scl_drv = 1'b1;
    sda_drv = 1'b1;
    bus.reg_valid = 1'b0;
    bus.reg_addr  = 4'h0;
    bus.reg_wstrb = 4'h0;
    bus.reg_wdata = 32'h0;
    resetn = 1'b0;
    clks(2);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_ready", 32'(bus.reg_ready), 32'd0);
    check("rst_rdata", bus.reg_rdata, 32'd0);
    check("rst_wr_evt", 32'(wr_evt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    clks(2);
    for (int i = 0; i < 16; i++)
      local_acc(4'(i), 1'b0, 8'h00, "rst_reg");

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h5A;
    i2c_wr(4'h3, 2, 1'b0, 4'h0, 8'h00);
    local_acc(4'h3, 1'b0, 8'h00, "reg3");
    local_acc(4'h4, 1'b0, 8'h00, "reg4");

    local_acc(4'hF, 1'b1, 8'h11, "wr_reg15");
    local_acc(4'h0, 1'b1, 8'h22, "wr_reg0");
    i2c_rd(4'hF, 2);

    o0 = oe_cnt;
    i2c_start();
    send_byte(8'h86, 1'b0, 4'h0, 8'h0, a);
    check("bad_addr_ack", 32'(a), 32'd0);
    check("bad_addr_busy", 32'(busy), 32'd0);
    i2c_stop();
    check("bad_addr_oe", 32'(oe_cnt - o0), 32'd0);
    local_acc(4'h3, 1'b0, 8'h00, "bad_addr_reg3");

    wbuf[0] = 8'h99;
    i2c_wr(4'h7, 1, 1'b1, 4'h7, 8'h33);
    local_acc(4'h7, 1'b0, 8'h00, "coll_reg7");
    wbuf[0] = 8'h77;
    i2c_wr(4'h7, 1, 1'b1, 4'h8, 8'h44);
    local_acc(4'h7, 1'b0, 8'h00, "coll2_reg7");
    local_acc(4'h8, 1'b0, 8'h00, "coll2_reg8");

    for (int it = 0; it < 6; it++) begin
      p = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      i2c_wr(p, n, 1'b0, 4'h0, 8'h00);
      for (int k = 0; k < 3; k++)
        local_acc(4'($urandom_range(0, 15)), 1'b0, 8'h00, "rand_lrd");
    end
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 2; k++)
        local_acc(4'($urandom_range(0, 15)), 1'b1,
                  8'($urandom), "rand_lwr");
      i2c_rd(4'($urandom_range(0, 15)), $urandom_range(1, 3));
    end

    local_acc(4'h5, 1'b1, 8'hF7, "wr_reg5");
    set_ptr(4'h5);
    i2c_start();
    send_byte(8'h85, 1'b0, 4'h0, 8'h0, a);
    check("mid_addr_ack", 32'(a), 32'd1);
    sda_drv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_bit(b);
      check("mid_hi_bit", 32'(b), 32'd1);
    end
    clks(8);
    check("mid_bit3_drive", 32'(sda_oe), 32'd1);
    resetn = 1'b0;
    clks(1);
    check("mid_rst_release", 32'(sda_oe), 32'd0);
    scl_drv = 1'b1;
    clks(2);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 4'h0;
    clks(4);
    check("mid_rst_busy", 32'(busy), 32'd0);
    i2c_rd(4'h0, 1);
    local_acc(4'h5, 1'b0, 8'h00, "mid_rst_reg5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
